// File: rtl/line_read_buffer.sv
// Single-entry read line buffer between the LC-3b data port and the 128-bit memory bus.
// A read miss fetches the whole line and keeps it for later hits. CPU writes to the line invalidate it.
module line_read_buffer (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic [15:0]  pmem_address,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RESPOND
    } state_t;

    state_t       state;
    logic [127:0] buf_line;
    logic [11:0]  buf_tag;
    logic         buf_valid;
    logic [11:0]  req_tag;
    logic         discard;

    logic [11:0]  addr_tag;
    logic [2:0]   word_sel;
    logic         buf_hit;
    logic         req_write;
    logic         unused_byte_bit;

    assign addr_tag  = mem_address[15:4];
    assign word_sel  = mem_address[3:1];
    assign buf_hit   = buf_valid && (addr_tag == buf_tag);
    assign req_write = mem_write && (addr_tag == req_tag);

    // Bit 0 selects a byte inside the word; the datapath handles that.
    assign unused_byte_bit = mem_address[0];

    function automatic logic [15:0] select_word(input logic [127:0] line, input logic [2:0] sel);
        return line[{sel, 4'b0000} +: 16];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            buf_line     <= '0;
            buf_tag      <= '0;
            buf_valid    <= 1'b0;
            req_tag      <= '0;
            discard      <= 1'b0;
            mem_rdata    <= 16'h0000;
            mem_resp     <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_address <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    mem_resp <= 1'b0;
                    if (mem_write && buf_hit) begin
                        buf_valid <= 1'b0;
                    end
                    // A simultaneous write wins, so a read with write is always served from memory.
                    if (mem_read) begin
                        if (buf_hit && !mem_write) begin
                            mem_rdata <= select_word(buf_line, word_sel);
                            mem_resp  <= 1'b1;
                            state     <= RESPOND;
                        end else begin
                            req_tag      <= addr_tag;
                            discard      <= 1'b0;
                            pmem_read    <= 1'b1;
                            pmem_address <= {addr_tag, 4'b0000};
                            state        <= FETCH;
                        end
                    end
                end

                FETCH: begin
                    if (req_write) begin
                        discard <= 1'b1;
                    end
                    // The word offset is taken from the address present when the line arrives.
                    if (pmem_resp) begin
                        mem_rdata <= select_word(pmem_rdata, word_sel);
                        buf_line  <= pmem_rdata;
                        buf_tag   <= req_tag;
                        buf_valid <= !discard && !req_write;
                        pmem_read <= 1'b0;
                        mem_resp  <= 1'b1;
                        state     <= RESPOND;
                    end
                end

                RESPOND: begin
                    mem_resp <= 1'b0;
                    if (mem_write && buf_hit) begin
                        buf_valid <= 1'b0;
                    end
                    state <= IDLE;
                end

                default: begin
                    mem_resp  <= 1'b0;
                    pmem_read <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_read_buffer.sv
// Scoreboard bench for line_read_buffer: a buffered-line model predicts each read's word and latency,
// a memory responder serves expected fetches, and a monitor checks every mem_resp pulse.
module tb_line_read_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    line_read_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    typedef struct {
        logic [15:0] word;
        int          latency;
    } exp_t;

    typedef struct {
        logic [127:0] line;
        int           delay;
        logic [15:0]  line_addr;
    } fetch_t;

    exp_t   exp_q[$];
    fetch_t fetch_q[$];
    int     checks = 0;
    int     passes = 0;
    int     issue_cycle = 0;
    bit     manual = 1'b0;

    // Reference view of the buffer: which line is held and whether a hit may use it.
    bit           m_valid = 1'b0;
    logic [11:0]  m_tag = '0;
    logic [127:0] m_line = '0;

    function automatic logic [15:0] word_of(input logic [127:0] line, input logic [2:0] k);
        return line[int'(k) * 16 +: 16];
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    // Monitor: every mem_resp pulse must match the oldest outstanding expectation.
    logic prev_resp = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            prev_resp = 1'b0;
        end else begin
            if (mem_resp) begin
                checkOutput("resp_single_pulse", prev_resp, 1'b0);
                checkOutput("resp_expected_pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("mem_rdata", mem_rdata, e.word);
                    checkOutput("resp_latency", cycle - issue_cycle, e.latency);
                end
            end
            prev_resp = mem_resp;
        end
    end

    // Physical memory responder serving only fetches the model predicted.
    initial begin : responder
        fetch_t f;
        bit     expected_fetch;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!manual && !reset && pmem_read) begin
                expected_fetch = fetch_q.size() > 0;
                checkOutput("fetch_expected", expected_fetch, 1'b1);
                if (expected_fetch) begin
                    f = fetch_q.pop_front();
                    checkOutput("pmem_address", pmem_address, f.line_addr);
                end else begin
                    f.line  = '0;
                    f.delay = 1;
                end
                repeat (f.delay) @(posedge clk);
                #1;
                checkOutput("pmem_read_held", pmem_read, 1'b1);
                if (expected_fetch) checkOutput("pmem_address_stable", pmem_address, f.line_addr);
                pmem_resp  = 1'b1;
                pmem_rdata = f.line;
                @(posedge clk);
                #1;
                pmem_resp  = 1'b0;
                pmem_rdata = rand_line();
                @(negedge clk);
                checkOutput("pmem_read_drop", pmem_read, 1'b0);
            end
        end
    end

    // CPU read; a write strobe may accompany the request or be pulsed once during the fetch.
    task automatic applyStimulus(input logic [15:0] addr, input bit rw_same, input bit fw,
                                 input logic [15:0] fw_addr, input logic [127:0] line, input int delay);
        exp_t        e;
        fetch_t      f;
        bit          hit;
        int          waited;
        logic [11:0] tag;
        tag = addr[15:4];
        hit = m_valid && (m_tag == tag) && !rw_same;
        if (hit) begin
            e.word    = word_of(m_line, addr[3:1]);
            e.latency = 1;
        end else begin
            f.line      = line;
            f.delay     = delay;
            f.line_addr = {tag, 4'h0};
            fetch_q.push_back(f);
            e.word    = word_of(line, addr[3:1]);
            e.latency = delay + 2;
            m_tag     = tag;
            m_line    = line;
            m_valid   = !(fw && (fw_addr[15:4] == tag));
        end
        @(posedge clk);
        #1;
        mem_address = addr;
        mem_read    = 1'b1;
        mem_write   = rw_same;
        issue_cycle = cycle;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        if (!hit && fw) begin
            mem_address = fw_addr;
            mem_write   = 1'b1;
            @(posedge clk);
            #1;
            mem_write   = 1'b0;
            mem_address = addr;
        end
        waited = 0;
        while (mem_resp !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("resp_within_bound", waited < 40, 1'b1);
        if (waited >= 40 && exp_q.size() > 0) void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        mem_read = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] addr);
        if (m_valid && m_tag == addr[15:4]) m_valid = 1'b0;
        @(posedge clk);
        #1;
        mem_address = addr;
        mem_write   = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic reset_mid_fetch();
        bit seen;
        manual = 1'b1;
        @(posedge clk);
        #1;
        mem_address = 16'h0040;
        mem_read    = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("pmem_read_fetch", pmem_read, 1'b1);
        checkOutput("pmem_address_fetch", pmem_address, 16'h0040);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset_pmem_read", pmem_read, 1'b0);
        checkOutput("reset_mem_resp", mem_resp, 1'b0);
        checkOutput("reset_pmem_address", pmem_address, 16'h0000);
        mem_read = 1'b0;
        m_valid  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_resp || pmem_read) seen = 1'b1;
        end
        checkOutput("stray_pmem_resp_ignored", seen, 1'b0);
        manual = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : main
        logic [127:0] ramp;
        logic [15:0]  addr;
        logic [15:0]  waddr;
        logic [11:0]  tag;
        logic [3:0]   off;
        int           op;
        ramp        = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        reset       = 1'b1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mem_resp", mem_resp, 1'b0);
        checkOutput("rst_mem_rdata", mem_rdata, 16'h0000);
        checkOutput("rst_pmem_read", pmem_read, 1'b0);
        checkOutput("rst_pmem_address", pmem_address, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(16'h0046, 1'b0, 1'b0, 16'h0, ramp, 3);
        applyStimulus(16'h004E, 1'b0, 1'b0, 16'h0, rand_line(), 2);
        do_write(16'h0042);
        applyStimulus(16'h0044, 1'b0, 1'b0, 16'h0, rand_line(), 2);
        applyStimulus(16'h1230, 1'b0, 1'b1, 16'h123A, rand_line(), 3);
        applyStimulus(16'h1230, 1'b0, 1'b0, 16'h0, rand_line(), 1);
        reset_mid_fetch();
        applyStimulus(16'h0040, 1'b0, 1'b0, 16'h0, rand_line(), 2);
        applyStimulus(16'h0040, 1'b0, 1'b0, 16'h0, rand_line(), 2);
        applyStimulus(16'h0048, 1'b1, 1'b0, 16'h0, rand_line(), 2);
        applyStimulus(16'h0048, 1'b0, 1'b0, 16'h0, rand_line(), 2);

        for (int i = 0; i < 150; i++) begin
            op  = $urandom_range(0, 9);
            tag = ($urandom_range(0, 2) == 0) ? m_tag : 12'($urandom_range(0, 3));
            off = 4'($urandom_range(0, 15));
            addr = {tag, off};
            waddr = ($urandom_range(0, 1) == 0) ? {tag, 4'($urandom_range(0, 15))}
                                                : {12'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            if (op < 2) do_write(addr);
            else applyStimulus(addr, op == 2, op == 3 || op == 4, waddr, rand_line(), $urandom_range(1, 5));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        checkOutput("fetch_queue_drained", fetch_q.size(), 0);
        checkOutput("resp_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
